// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID pipeline register.
// Optional stall/flush event counters are built when IF_STAGE_PERF_CNT_EN is defined;
// otherwise stall_cnt_o / flush_cnt_o are tied to zero.
module if_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter logic [31:0]     BUBBLE_INSTR = 32'h0,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_instr_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  pc_id_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned INSTR_W = 32;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [XLEN-1:0]    pc_id_q, pc_id_d;
  logic               valid_q, valid_d;

  // Next-state selection: idle > stall > flush > sequential fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    if (!start_i) begin
      instr_d = BUBBLE_INSTR;
      pc_id_d = '0;
      valid_d = 1'b0;
    end else if (stall_i) begin
      // Hold everything; a branch seen while stalled is re-raised later.
    end else if (flush_i) begin
      pc_d    = branch_target_i & ~XLEN'(3);
      instr_d = BUBBLE_INSTR;
      pc_id_d = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q + XLEN'(4);
      instr_d = imem_instr_i;
      pc_id_d = pc_q;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= BUBBLE_INSTR;
      pc_id_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_id_o     = pc_id_q;
  assign valid_o     = valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; a flush under stall is not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_i && stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (start_i && !stall_i && flush_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
